// File: rtl/guess_input_conditioner.sv
// Button front-end for the whack-a-mole game. It synchronises and debounces the inputs, encodes the guess and generates restart.
// Optional macro LONG_PRESS_RESTART_EN: restart requires btnCenter to be held instead of firing on a press edge.
`timescale 1ns/1ps
module guess_input_conditioner #(
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int RESTART_HOLD_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnCenter,
  input  logic       sw,
  output logic [2:0] user_guess,
  output logic       eval_now,
  output logic       rst
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // Bit order matches the direction codes: 0 Up, 1 Right, 2 Down, 3 Left, then 4 Center, 5 sw.
  logic [5:0]    w_raw;
  logic [5:0]    r_sync1;
  logic [5:0]    r_sync2;
  logic [5:0]    r_db;
  logic [CW-1:0] r_cnt [6];
  logic [3:0]    r_dir_d;
  logic [3:0]    w_dir_rise;
  logic          w_restart;
  logic [1:0]    w_code;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    w_guess_nxt;
  logic          w_eval_nxt;
  logic          w_rst_nxt;
  logic [2:0]    r_guess;
  logic          r_eval;
  logic          r_rst;

  assign w_raw = {sw, btnCenter, btnLeft, btnDown, btnRight, btnUp};

  // Two-flop synchronisers for every raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 6'b0;
      r_sync2 <= 6'b0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-input debounce: the level toggles only after DEBOUNCE_CYCLES differing samples in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db <= 6'b0;
      for (int i = 0; i < 6; i++) r_cnt[i] <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= {CW{1'b0}};
        end else if (r_cnt[i] == DB_MAX) begin
          r_db[i]  <= ~r_db[i];
          r_cnt[i] <= {CW{1'b0}};
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Previous debounced direction levels for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir_d <= 4'b0;
    end else begin
      r_dir_d <= r_db[3:0];
    end
  end

  assign w_dir_rise = r_db[3:0] & ~r_dir_d;

`ifdef LONG_PRESS_RESTART_EN
  localparam int HW = (RESTART_HOLD_CYCLES > 1) ? $clog2(RESTART_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(RESTART_HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(RESTART_HOLD_CYCLES - 2);
  logic [HW-1:0] r_hold;

  // Hold counter saturates so a single long hold yields exactly one restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= {HW{1'b0}};
    end else if (!r_db[4]) begin
      r_hold <= {HW{1'b0}};
    end else if (r_hold != HOLD_MAX) begin
      r_hold <= r_hold + HW'(1);
    end else begin
      r_hold <= r_hold;
    end
  end

  assign w_restart = r_db[4] && (r_hold == HOLD_FIRE);
`else
  logic r_ctr_d;

  // Previous debounced btnCenter level for restart edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr_d <= 1'b0;
    end else begin
      r_ctr_d <= r_db[4];
    end
  end

  assign w_restart = r_db[4] & ~r_ctr_d;
`endif

  // Direction FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Direction FSM next state; restart always parks the FSM in HELD
  always_comb begin
    w_state_nxt = r_state;
    if (w_restart) begin
      w_state_nxt = ST_HELD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_dir_rise) w_state_nxt = ST_HELD;
          else             w_state_nxt = ST_IDLE;
        end
        ST_HELD: begin
          if (r_db[3:0] == 4'b0) w_state_nxt = ST_IDLE;
          else                   w_state_nxt = ST_HELD;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Fixed-priority encoder Up > Right > Down > Left
  always_comb begin
    w_code = 2'd3;
    if (w_dir_rise[0])      w_code = 2'd0;
    else if (w_dir_rise[1]) w_code = 2'd1;
    else if (w_dir_rise[2]) w_code = 2'd2;
    else                    w_code = 2'd3;
  end

  // Direction FSM outputs, registered below
  always_comb begin
    w_guess_nxt = r_guess;
    w_eval_nxt  = 1'b0;
    w_rst_nxt   = w_restart;
    if (w_restart) begin
      w_guess_nxt = 3'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_dir_rise) begin
            w_guess_nxt = {r_db[5], w_code};
            w_eval_nxt  = 1'b1;
          end else begin
            w_guess_nxt = r_guess;
          end
        end
        ST_HELD: w_guess_nxt = r_guess;
        default: w_guess_nxt = r_guess;
      endcase
    end
  end

  // Output registers; rst comes out of reset high to give a power-on restart pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_guess <= 3'b0;
      r_eval  <= 1'b0;
      r_rst   <= 1'b1;
    end else begin
      r_guess <= w_guess_nxt;
      r_eval  <= w_eval_nxt;
      r_rst   <= w_rst_nxt;
    end
  end

  assign user_guess = r_guess;
  assign eval_now   = r_eval;
  assign rst        = r_rst;

endmodule

// File: tb/tb_guess_input_conditioner.sv
// Scoreboard bench for guess_input_conditioner with DEBOUNCE_CYCLES=8 and RESTART_HOLD_CYCLES=32.
`timescale 1ns/1ps
module tb_guess_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
  logic       btnCenter = 1'b0, sw = 1'b0;
  logic [2:0] user_guess;
  logic       eval_now, rst;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [2:0] g;
    int         c;
  } exp_t;
  exp_t eval_q[$];
  int   rst_q[$];

  guess_input_conditioner #(.DEBOUNCE_CYCLES(8), .RESTART_HOLD_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft),
    .btnRight(btnRight), .btnCenter(btnCenter), .sw(sw),
    .user_guess(user_guess), .eval_now(eval_now), .rst(rst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Press-to-strobe latency is DEBOUNCE_CYCLES+3 = 11 cycles
  task automatic expect_eval(input logic [2:0] g);
    exp_t e;
    e.g = g;
    e.c = cyc + 11;
    eval_q.push_back(e);
  endtask

  task automatic run_monitor();
    exp_t e;
    int   rc;
    logic prev_eval = 1'b0;
    logic prev_rst  = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (eval_now && prev_eval) check("eval_back_to_back", 32'd1, 32'd0);
        if (rst && prev_rst)       check("rst_back_to_back", 32'd1, 32'd0);
        if (eval_now) begin
          if (eval_q.size() == 0) begin
            check("eval_unexpected", 32'd1, 32'd0);
          end else begin
            e = eval_q.pop_front();
            check("eval_guess", 32'(user_guess), 32'(e.g));
            check("eval_cycle", cyc, e.c);
          end
        end
        if (rst) begin
          if (rst_q.size() == 0) begin
            check("rst_unexpected", 32'd1, 32'd0);
          end else begin
            rc = rst_q.pop_front();
            check("rst_cycle", cyc, rc);
            check("rst_guess_cleared", 32'(user_guess), 32'd0);
            check("rst_eval_cleared", 32'(eval_now), 32'd0);
          end
        end
      end
      prev_eval = eval_now;
      prev_rst  = rst;
    end
  endtask

  initial begin
    fork
      run_monitor();
    join_none

    // Reset and power-on restart pulse
    #23;
    check("reset_rst", 32'(rst), 32'd1);
    check("reset_guess", 32'(user_guess), 32'd0);
    check("reset_eval", 32'(eval_now), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_before_edge", 32'(rst), 32'd1);
    @(posedge clk);
    #1;
    check("rst_after_edge", 32'(rst), 32'd0);
    mon_en = 1'b1;
    tick(20);

    // sw=1, hold Left 20 cycles
    sw = 1'b1;
    tick(15);
    btnLeft = 1'b1;
    expect_eval(3'b111);
    tick(20);
    btnLeft = 1'b0;
    tick(25);

    // 5-cycle Up glitch must be filtered
    btnUp = 1'b1;
    tick(5);
    btnUp = 1'b0;
    tick(20);
    check("guess_after_glitch", 32'(user_guess), 32'd7);

    // Up and Down together: Up wins, one strobe
    sw = 1'b0;
    tick(15);
    btnUp = 1'b1;
    btnDown = 1'b1;
    expect_eval(3'b000);
    tick(15);
    btnUp = 1'b0;
    btnDown = 1'b0;
    tick(25);

    // Right held, Down pressed during hold: ignored
    btnRight = 1'b1;
    expect_eval(3'b001);
    tick(15);
    btnDown = 1'b1;
    tick(15);
    btnRight = 1'b0;
    btnDown = 1'b0;
    tick(25);
    btnDown = 1'b1;
    expect_eval(3'b010);
    tick(15);
    btnDown = 1'b0;
    tick(25);

    // Switch toggles alone never strobe or alter the held guess
    sw = 1'b1;
    tick(20);
    check("guess_sw_idle", 32'(user_guess), 32'd2);
    btnUp = 1'b1;
    expect_eval(3'b100);
    tick(15);
    sw = 1'b0;
    tick(20);
    check("guess_sw_held", 32'(user_guess), 32'd4);
    btnUp = 1'b0;
    tick(25);

    // Restart via btnCenter
`ifdef LONG_PRESS_RESTART_EN
    btnCenter = 1'b1;
    tick(10);
    btnCenter = 1'b0;
    tick(30);
    check("short_press_keeps_guess", 32'(user_guess), 32'd4);
    btnCenter = 1'b1;
    rst_q.push_back(cyc + 41);
    tick(50);
    btnCenter = 1'b0;
    tick(30);
`else
    btnCenter = 1'b1;
    rst_q.push_back(cyc + 11);
    tick(10);
    btnCenter = 1'b0;
    tick(30);
`endif
    check("guess_after_restart", 32'(user_guess), 32'd0);
    btnLeft = 1'b1;
    expect_eval(3'b011);
    tick(15);
    btnLeft = 1'b0;
    tick(25);

    // Mid-operation rst_n with a debounce counter in flight
    btnRight = 1'b1;
    tick(5);
    check("guess_before_rstn", 32'(user_guess), 32'd3);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midrst_rst", 32'(rst), 32'd1);
    check("midrst_guess", 32'(user_guess), 32'd0);
    check("midrst_eval", 32'(eval_now), 32'd0);
    btnRight = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rst_release", 32'(rst), 32'd0);
    mon_en = 1'b1;
    tick(5);
    btnDown = 1'b1;
    expect_eval(3'b010);
    tick(15);
    btnDown = 1'b0;
    tick(30);

    check("eval_queue_drained", eval_q.size(), 32'd0);
    check("rst_queue_drained", rst_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
